// File: rtl/rr_bus_arbiter4_pkg.sv
// Shared definitions for the 4-way round-robin bus arbiter: default data
// width, FSM state encoding and the round-robin winner search.
package rr_bus_arbiter4_pkg;

   localparam int BUS_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   // Round-robin pick: search starts just after the last owner and wraps 3->0,
   // so the last owner itself is considered last. Returns last_owner when
   // nothing is requesting; callers only use the result when req != 0.
   function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] last_owner);
      logic [1:0] idx;
      logic       found;
      rr_pick = last_owner;
      found   = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = last_owner + 2'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

endpackage

// File: rtl/rr_bus_arbiter4_mux4x1.sv
// 4:1 data multiplexer that drives the shared bus from the current owner.
module rr_bus_arbiter4_mux4x1
   import rr_bus_arbiter4_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH
) (
   input  logic [1:0]       sel2,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [WIDTH-1:0] in3,
   output logic [WIDTH-1:0] out
);

   // Select one of the four inputs.
   always_comb begin
      out = in0;
      case (sel2)
         2'd0:    out = in0;
         2'd1:    out = in1;
         2'd2:    out = in2;
         2'd3:    out = in3;
         default: out = in0;
      endcase
   end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Four-requester round-robin bus arbiter with a one-cycle turnaround between
// grants and a hold-time limit that forcibly revokes a stuck grant.
module rr_bus_arbiter4 #(
   parameter int BUS_WIDTH      = rr_bus_arbiter4_pkg::BUS_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           req,
   input  logic [3:0]           done,
   input  logic [BUS_WIDTH-1:0] wdata0,
   input  logic [BUS_WIDTH-1:0] wdata1,
   input  logic [BUS_WIDTH-1:0] wdata2,
   input  logic [BUS_WIDTH-1:0] wdata3,
   output logic [3:0]           gnt,
   output logic [1:0]           sel2,
   output logic [BUS_WIDTH-1:0] bus_out,
   output logic                 bus_valid,
   output logic                 timeout
);

   import rr_bus_arbiter4_pkg::*;

   // Counter only has to reach TIMEOUT_CYCLES-1.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_e       state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel2_q, sel2_d;
   logic             bus_valid_q, bus_valid_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       last_owner_q, last_owner_d;

   logic [1:0]       winner_s;
   logic             done_own_s;
   logic             req_own_s;
   logic             expired_s;
   logic             release_s;

   assign winner_s   = rr_pick(req, last_owner_q);
   assign done_own_s = done[sel2_q];
   assign req_own_s  = req[sel2_q];
   assign expired_s  = (cnt_q == CNT_MAX);
   assign release_s  = done_own_s | ~req_own_s | expired_s;

   // Next-state and next-output logic for the IDLE/GRANT/RELEASE sequence.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      sel2_d       = sel2_q;
      bus_valid_d  = bus_valid_q;
      timeout_d    = 1'b0;
      cnt_d        = cnt_q;
      last_owner_d = last_owner_q;
      case (state_q)
         IDLE, RELEASE: begin
            if (req != 4'b0000) begin
               state_d     = GRANT;
               gnt_d       = 4'b0001 << winner_s;
               sel2_d      = winner_s;
               bus_valid_d = 1'b1;
               cnt_d       = {CNT_W{1'b0}};
            end else begin
               state_d     = IDLE;
               gnt_d       = 4'b0000;
               bus_valid_d = 1'b0;
            end
         end
         GRANT: begin
            if (release_s) begin
               state_d      = RELEASE;
               gnt_d        = 4'b0000;
               bus_valid_d  = 1'b0;
               last_owner_d = sel2_q;
               // A done or req drop in the expiry cycle counts as a normal end.
               timeout_d    = expired_s & ~done_own_s & req_own_s;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               cnt_d        = cnt_q;
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = 4'b0000;
            bus_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops any grant immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         gnt_q        <= 4'b0000;
         sel2_q       <= 2'd0;
         bus_valid_q  <= 1'b0;
         timeout_q    <= 1'b0;
         cnt_q        <= {CNT_W{1'b0}};
         last_owner_q <= 2'd3;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         sel2_q       <= sel2_d;
         bus_valid_q  <= bus_valid_d;
         timeout_q    <= timeout_d;
         cnt_q        <= cnt_d;
         last_owner_q <= last_owner_d;
      end
   end

   assign gnt       = gnt_q;
   assign sel2      = sel2_q;
   assign bus_valid = bus_valid_q;
   assign timeout   = timeout_q;

   rr_bus_arbiter4_mux4x1 #(
      .WIDTH (BUS_WIDTH)
   ) u_bus_mux (
      .sel2 (sel2_q),
      .in0  (wdata0),
      .in1  (wdata1),
      .in2  (wdata2),
      .in3  (wdata3),
      .out  (bus_out)
   );

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Bench for rr_bus_arbiter4: directed reset/latency cases, then randomized
// transactions predicted by a transaction-level model and checked by a monitor.
module tb_rr_bus_arbiter4;

   localparam int W  = 32;
   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [3:0]   done;
   logic [W-1:0] wdata [4];
   logic [3:0]   gnt;
   logic [1:0]   sel2;
   logic [W-1:0] bus_out;
   logic         bus_valid;
   logic         timeout;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int owner;
      int len;
      bit to;
   } exp_t;

   exp_t sb_q[$];
   bit   mon_en   = 1'b0;
   bit   in_grant = 1'b0;

   rr_bus_arbiter4 #(
      .BUS_WIDTH      (W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .wdata0    (wdata[0]),
      .wdata1    (wdata[1]),
      .wdata2    (wdata[2]),
      .wdata3    (wdata[3]),
      .gnt       (gnt),
      .sel2      (sel2),
      .bus_out   (bus_out),
      .bus_valid (bus_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arbitration: first pending requester after last owner, wrapping.
   function automatic int rr_model(input logic [3:0] p, input int last);
      for (int k = 1; k <= 4; k++) begin
         if (p[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic rand_wdata();
      for (int i = 0; i < 4; i++) wdata[i] = $urandom;
   endtask

   // Monitor: pops one expected grant per observed grant and checks it.
   initial begin : monitor
      exp_t       cur;
      bit         have_cur;
      int         cur_len;
      logic [3:0] one_hot;
      have_cur = 1'b0;
      cur_len  = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus_valid) begin
               if (!in_grant) begin
                  in_grant = 1'b1;
                  cur_len  = 0;
                  if (sb_q.size() == 0) begin
                     have_cur = 1'b0;
                     check("unexpected_grant", 64'd1, 64'd0);
                  end else begin
                     cur      = sb_q.pop_front();
                     have_cur = 1'b1;
                  end
               end
               cur_len++;
               if (have_cur) begin
                  one_hot = 4'b0001 << cur.owner;
                  check("sel2", 64'(sel2), 64'(cur.owner));
                  check("gnt", 64'(gnt), 64'(one_hot));
                  check("bus_out", 64'(bus_out), 64'(wdata[cur.owner]));
               end
               check("timeout_in_grant", 64'(timeout), 64'd0);
            end else begin
               check("gnt_when_invalid", 64'(gnt), 64'd0);
               if (in_grant) begin
                  in_grant = 1'b0;
                  if (have_cur) begin
                     check("grant_len", 64'(cur_len), 64'(cur.len));
                     check("timeout_pulse", 64'(timeout), 64'(cur.to));
                  end
               end else begin
                  check("timeout_quiet", 64'(timeout), 64'd0);
               end
            end
         end
      end
   end

   // Stimulus: directed cases first, then randomized transactions.
   initial begin : driver
      logic [3:0] pending;
      int         last, w, mode, l_end, len;
      bit         to;
      logic [3:0] own;

      rst  = 1'b1;
      req  = 4'b0000;
      done = 4'b0000;
      wdata[0] = 32'hA5A5_0000;
      wdata[1] = 32'hA5A5_0001;
      wdata[2] = 32'hA5A5_0002;
      wdata[3] = 32'hA5A5_0003;
      #12;
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_sel2", 64'(sel2), 64'd0);
      check("rst_valid", 64'(bus_valid), 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);

      // First request after reset: granted one cycle later.
      @(negedge clk); rst = 1'b0;
      @(negedge clk); req = 4'b0001;
      @(negedge clk);
      check("first_gnt", 64'(gnt), 64'h1);
      check("first_sel2", 64'(sel2), 64'd0);
      check("first_valid", 64'(bus_valid), 64'd1);
      check("first_bus_out", 64'(bus_out), 64'hA5A5_0000);
      done = 4'b0001;
      @(negedge clk); done = 4'b0000; req = 4'b0000;
      check("turnaround_gnt", 64'(gnt), 64'd0);
      check("turnaround_valid", 64'(bus_valid), 64'd0);

      // Owner 2 released by done while requester 1 waits.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; wdata[2] = 32'hDEAD_BEEF; req = 4'b0100;
      @(negedge clk);
      check("own2_gnt", 64'(gnt), 64'h4);
      check("own2_bus_out", 64'(bus_out), 64'hDEAD_BEEF);
      req = 4'b0110; done = 4'b0100;
      @(negedge clk); done = 4'b0000; req = 4'b0010;
      check("own2_release_gnt", 64'(gnt), 64'd0);
      @(negedge clk);
      check("own2_next_gnt", 64'(gnt), 64'h2);
      req = 4'b0000;
      @(negedge clk);

      // Asynchronous reset in the middle of owner 3's grant.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; req = 4'b1000;
      @(negedge clk);
      check("own3_gnt", 64'(gnt), 64'h8);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_gnt", 64'(gnt), 64'd0);
      check("async_rst_valid", 64'(bus_valid), 64'd0);
      check("async_rst_timeout", 64'(timeout), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("post_rst_gnt", 64'(gnt), 64'h8);
      check("post_rst_sel2", 64'(sel2), 64'd3);
      req = 4'b0000;

      // Randomized transactions against the reference model.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0; mon_en = 1'b1;
      last    = 3;
      pending = 4'b0000;
      @(posedge clk); #1;
      for (int tr = 0; tr < 300; tr++) begin
         if (pending == 4'b0000) begin
            req  = 4'b0000;
            done = 4'($urandom);
            rand_wdata();
            repeat ($urandom_range(0, 2) + 1) begin
               @(posedge clk); #1;
               req  = 4'b0000;
               done = 4'($urandom);
               rand_wdata();
            end
            pending = 4'($urandom_range(1, 15));
         end
         // Arbitration cycle.
         req  = pending;
         done = 4'($urandom);
         rand_wdata();
         w    = rr_model(pending, last);
         own  = 4'b0001 << w;
         mode = $urandom_range(0, 2);
         if (mode == 0) begin
            l_end = $urandom_range(1, TO); len = l_end; to = 1'b0;
         end else if (mode == 1) begin
            l_end = $urandom_range(1, TO - 1); len = l_end; to = 1'b0;
         end else begin
            l_end = TO + 1; len = TO; to = 1'b1;
         end
         sb_q.push_back('{owner: w, len: len, to: to});
         for (int j = 1; j <= len; j++) begin
            @(posedge clk); #1;
            rand_wdata();
            if ($urandom_range(0, 3) == 0) pending = pending | (4'($urandom) & ~own);
            if ($urandom_range(0, 7) == 0) pending = pending & ~(4'($urandom) & ~own);
            if (mode == 1 && j == l_end) pending = pending & ~own;
            req  = pending;
            done = (4'($urandom) & ~own) | ((mode == 0 && j == l_end) ? own : 4'b0000);
         end
         // Release cycle: this cycle also arbitrates if anyone is pending.
         @(posedge clk); #1;
         last = w;
         if (mode != 1 && $urandom_range(0, 1) == 0) pending = pending & ~own;
      end
      req  = 4'b0000;
      done = 4'b0000;
      repeat (4) @(posedge clk);
      @(negedge clk);
      mon_en = 1'b0;
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      check("no_open_grant", 64'(in_grant), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_bus_arbiter4.md
RR_BUS_ARBITER4 -- requirements
Module: rr_bus_arbiter4

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32 (shared package constant), width of each data path.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum number of cycles one grant may be held.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  4  request from requester i (bit i).
REQ-006 SHALL have port done  input  4  end-of-transfer pulse from requester i.
REQ-007 SHALL have ports wdata0..wdata3  input  BUS_WIDTH each  data offered by requester i.
REQ-008 SHALL have port gnt  output  4  one-hot grant, registered.
REQ-009 SHALL have port sel2  output  2  index of current owner, registered.
REQ-010 SHALL have port bus_out  output  BUS_WIDTH  shared bus, wdata[sel2].
REQ-011 SHALL have port bus_valid  output  1  high while a grant is active.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT and RELEASE.
REQ-014 In IDLE with req != 0, SHALL select the winner and enter GRANT next cycle; gnt, sel2 and bus_valid are valid one cycle after req is sampled.
REQ-015 Winner SHALL be round-robin: search order starts at last_owner+1 mod 4 and wraps 3->0.
REQ-016 In GRANT, gnt SHALL be one-hot at bit sel2 and bus_valid SHALL be 1.
REQ-017 In GRANT, the grant SHALL end (enter RELEASE) on the first of these: done[owner]=1; req[owner]=0; hold counter = TIMEOUT_CYCLES-1.
REQ-018 done or req changes of non-owners during GRANT SHALL be ignored.
REQ-019 When done[owner] and timeout expiry coincide, SHALL treat it as a normal release, with no timeout pulse.
REQ-020 On timeout-driven release, timeout SHALL pulse high for exactly the first RELEASE cycle.
REQ-021 RELEASE SHALL last one cycle with gnt=0 and bus_valid=0 (bus turnaround); last_owner SHALL be updated to the released owner.
REQ-022 From RELEASE, if req != 0, SHALL arbitrate and enter GRANT next cycle; otherwise SHALL enter IDLE. Minimum done-to-next-gnt latency is 2 cycles.
REQ-023 Hold counter SHALL clear on GRANT entry and increment by 1 per GRANT cycle; it SHALL never wrap.
REQ-024 sel2 SHALL hold its last value outside GRANT.
REQ-025 bus_out SHALL be combinational from sel2 and wdata; its contents are defined only while bus_valid=1.
REQ-026 A requester that holds req continuously SHALL be re-granted only after every other pending requester has been served once (no starvation).

Reset
REQ-027 rst SHALL immediately, asynchronously force: state=IDLE, gnt=0000, sel2=00, bus_valid=0, timeout=0, counter=0, last_owner=3 (requester 0 highest priority after reset).
REQ-028 Reset asserted mid-GRANT SHALL drop the grant without a RELEASE cycle or timeout pulse.

Structure
REQ-029 BUS_WIDTH and the FSM state typedef (IDLE/GRANT/RELEASE) SHALL live in the shared header package.
REQ-030 bus_out SHALL be produced by one instance of the existing MUX4x1 sub-module (sel2 -> sel2, wdata0..3 -> in0..in3).
REQ-031 The round-robin winner search SHALL be a combinational function of req and last_owner.

Verification
REQ-032 Reset, then req=0001 -> next cycle gnt=0001, sel2=0, bus_valid=1, bus_out=wdata0.
REQ-033 From reset, req=1111 held with done pulsed each grant -> grant order 0,1,2,3,0, one RELEASE cycle between grants.
REQ-034 Owner 2, wdata2=32'hDEADBEEF, done[2] in cycle M -> gnt=0 at M+1; with req[1] pending, gnt=0010 at M+2.
REQ-035 TIMEOUT_CYCLES=4, owner 1 holds req with no done -> grant lasts 4 cycles, timeout pulses 1 cycle, next pending requester is granted.
REQ-036 rst asserted mid-GRANT of owner 3 -> gnt=0000 and bus_valid=0 without waiting for a clock edge; after release, req=1000 -> gnt=1000.
REQ-037 Owner 0 drops req without done, while done[3] is pulsed by non-owner 3 -> release is caused by the req drop only, timeout stays 0, and done[3] has no effect.
